// File: rtl/mem_lsu.sv
// Multi-cycle MEM-stage load/store unit driving a req/ack data bus, with flush-safe draining.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module mem_lsu #(
    parameter int         ADDR_W   = 32,
    parameter logic [4:0] EXC_ADEL = 5'h04,
    parameter logic [4:0] EXC_ADES = 5'h05,
    parameter logic [4:0] EXC_DBE  = 5'h07,
    parameter int         TIMEOUT  = 255
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              ls_valid_i,
    input  logic              ls_load_i,
    input  logic              ls_store_i,
    input  logic [1:0]        ls_size_i,
    input  logic              ls_sext_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [31:0]       ls_wdata_i,
    input  logic              ls_flush_i,
    output logic              stall_o,
    output logic              ls_done_o,
    output logic [31:0]       ls_rdata_o,
    output logic              ls_exc_o,
    output logic [4:0]        ls_exccode_o,
    output logic [ADDR_W-1:0] ls_badvaddr_o,
    output logic              dreq_o,
    output logic [3:0]        dwe_o,
    output logic [ADDR_W-1:0] daddr_o,
    output logic [31:0]       dwdata_o,
    input  logic              dack_i,
    input  logic [31:0]       drdata_i
);

    // state | meaning
    // IDLE  | waiting for an access
    // BUSY  | dreq_o high, waiting for dack_i
    // DRAIN | flushed mid-access, finishing the bus handshake silently
    // DONE  | one-cycle completion (result or exception)
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DRAIN, ST_DONE} state_t;

    state_t state, state_nxt;

    logic              access, accept, is_load, misaligned, tmo_hit;
    logic [3:0]        lane_we;
    logic [31:0]       wdata_rep;
    logic [1:0]        size_q, off_q;
    logic              sext_q, load_q, exc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_ext;

    assign access     = ls_valid_i & (ls_load_i | ls_store_i);
    assign accept     = access & ~ls_flush_i;
    assign is_load    = ls_load_i;
    assign misaligned = ((ls_size_i == 2'b01) & ls_addr_i[0]) |
                        (ls_size_i[1] & (ls_addr_i[1:0] != 2'b00));

    // Big-endian lanes: offset 0 is bits [31:24], i.e. dwe_o[3].
    always_comb begin
        lane_we   = 4'b0000;
        wdata_rep = ls_wdata_i;
        case (ls_size_i)
            2'b00: begin
                lane_we   = 4'b1000 >> ls_addr_i[1:0];
                wdata_rep = {4{ls_wdata_i[7:0]}};
            end
            2'b01: begin
                lane_we   = ls_addr_i[1] ? 4'b0011 : 4'b1100;
                wdata_rep = {2{ls_wdata_i[15:0]}};
            end
            default: lane_we = 4'b1111;
        endcase
        if (is_load)
            lane_we = 4'b0000;
    end

    always_comb begin
        rd_byte = drdata_i[7:0];
        case (off_q)
            2'b00:   rd_byte = drdata_i[31:24];
            2'b01:   rd_byte = drdata_i[23:16];
            2'b10:   rd_byte = drdata_i[15:8];
            default: rd_byte = drdata_i[7:0];
        endcase
        rd_half = off_q[1] ? drdata_i[15:0] : drdata_i[31:16];
        case (size_q)
            2'b00:   load_ext = {{24{sext_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = {{16{sext_q & rd_half[15]}}, rd_half};
            default: load_ext = drdata_i;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst)
            tmo_cnt <= '0;
        else if (state_nxt != state)
            tmo_cnt <= '0;
        else if ((state == ST_BUSY || state == ST_DRAIN) && !dack_i)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Fires on the TIMEOUT-th consecutive cycle without an acknowledge.
    assign tmo_hit = (state == ST_BUSY || state == ST_DRAIN) && !dack_i &&
                     (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
    // No watchdog in this build: the bus is waited on indefinitely.
    assign tmo_hit = (TIMEOUT < 0);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = misaligned ? ST_DONE : ST_BUSY;
            ST_BUSY: begin
                if (dack_i)
                    state_nxt = ls_flush_i ? ST_IDLE : ST_DONE;
                else if (ls_flush_i)
                    state_nxt = ST_DRAIN;
                else if (tmo_hit)
                    state_nxt = ST_DONE;
            end
            ST_DRAIN: if (dack_i || tmo_hit) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state         <= ST_IDLE;
            daddr_o       <= '0;
            dwe_o         <= '0;
            dwdata_o      <= '0;
            addr_q        <= '0;
            size_q        <= '0;
            off_q         <= '0;
            sext_q        <= 1'b0;
            load_q        <= 1'b0;
            exc_q         <= 1'b0;
            ls_rdata_o    <= '0;
            ls_exccode_o  <= '0;
            ls_badvaddr_o <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (accept) begin
                    addr_q <= ls_addr_i;
                    if (misaligned) begin
                        exc_q         <= 1'b1;
                        ls_exccode_o  <= is_load ? EXC_ADEL : EXC_ADES;
                        ls_badvaddr_o <= ls_addr_i;
                        ls_rdata_o    <= '0;
                    end else begin
                        daddr_o      <= {ls_addr_i[ADDR_W-1:2], 2'b00};
                        dwe_o        <= lane_we;
                        dwdata_o     <= wdata_rep;
                        size_q       <= ls_size_i;
                        off_q        <= ls_addr_i[1:0];
                        sext_q       <= ls_sext_i;
                        load_q       <= is_load;
                        exc_q        <= 1'b0;
                        ls_exccode_o <= '0;
                    end
                end
                ST_BUSY: begin
                    if (dack_i) begin
                        ls_rdata_o <= load_q ? load_ext : 32'h0;
                    end else if (state_nxt == ST_DONE) begin
                        exc_q         <= 1'b1;
                        ls_exccode_o  <= EXC_DBE;
                        ls_badvaddr_o <= addr_q;
                        ls_rdata_o    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dreq_o    = (state == ST_BUSY) || (state == ST_DRAIN);
    assign stall_o   = ((state == ST_IDLE) && accept) || dreq_o;
    assign ls_done_o = (state == ST_DONE) && !ls_flush_i;
    assign ls_exc_o  = ls_done_o && exc_q;

endmodule
